// File: rtl/pkt_parser_pkg.sv
// Shared types and constants for the AXI-Stream packet parser.
// The stage sequencer and the parser stages import these definitions.
package pkt_parser_pkg;

  localparam int NUM_STAGES_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stage_state_e;

  // Stage vector at the default pipeline depth. Modules with a different
  // depth declare their own vector width from their NUM_STAGES parameter.
  typedef logic [NUM_STAGES_DEFAULT-1:0] stage_vec_t;

endpackage

// File: rtl/pkt_stage_counter.sv
// Header-triggered stage sequencer. A header beat on tuser walks a one-hot
// stage_ready enable through the parser pipeline, one stage per clock.
module pkt_stage_counter
  import pkt_parser_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tuser,
  output logic [NUM_STAGES-1:0] stage_ready
);

  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  stage_state_e          state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  stageOneHot;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  assign stageOneHot = (stage_q != '0) && ((stage_q & (stage_q - FIRST_STAGE)) == '0);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    if (tuser) begin
      state_d = RUN;
      stage_d = FIRST_STAGE;
    end else begin
      case (state_q)
        RUN: begin
          // A corrupted pointer or the final stage both end the window.
          if (!stageOneHot || stage_q[NUM_STAGES-1]) begin
            state_d = IDLE;
            stage_d = '0;
          end else begin
            stage_d = stage_q << 1;
          end
        end
        default: begin
          state_d = IDLE;
          stage_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  assign stage_ready = stage_q;

endmodule

// File: tb/tb_pkt_stage_counter.sv
// Self-checking bench for pkt_stage_counter: a position-based reference model
// compared every cycle, plus directed literal expectations per scenario.
module tb_pkt_stage_counter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tuser;
  logic [N-1:0] stage_ready;

  int checks = 0;
  int fails  = 0;

  // Active stage index of the current window, or -1 when idle.
  int modelPos = -1;

  pkt_stage_counter #(.NUM_STAGES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .tuser      (tuser),
    .stage_ready(stage_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] expVec(input int pos);
    logic [N-1:0] v;
    v = '0;
    if (pos >= 0) v[pos] = 1'b1;
    return v;
  endfunction

  // A header restarts the window at stage 0; otherwise the window walks
  // forward and closes after the last stage.
  always @(posedge clk or negedge rst) begin
    if (!rst) modelPos = -1;
    else if (tuser) modelPos = 0;
    else if (modelPos >= 0) modelPos = (modelPos == N - 1) ? -1 : modelPos + 1;
  end

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: output matches the model and is never multi-hot.
  always @(negedge clk) begin
    checkOutput("model", stage_ready, expVec(modelPos));
    checkOutput("onehot0", {{(N-1){1'b0}}, $onehot0(stage_ready)}, {{(N-1){1'b0}}, 1'b1});
  end

  // Drive tuser for one rising edge, return at the following falling edge.
  task automatic applyStimulus(input logic t);
    tuser = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stepExpect(input logic t, input logic [N-1:0] expected, input string name);
    applyStimulus(t);
    checkOutput(name, stage_ready, expected);
  endtask

  initial begin
    rst   = 1'b0;
    tuser = 1'b0;
    @(negedge clk);
    checkOutput("reset_value", stage_ready, 4'b0000);
    // Header flag during reset must be ignored.
    stepExpect(1'b1, 4'b0000, "tuser_in_reset");
    tuser = 1'b0;
    rst   = 1'b1;
    stepExpect(1'b0, 4'b0000, "post_reset_idle0");
    stepExpect(1'b0, 4'b0000, "post_reset_idle1");

    $display("[TB] single header");
    stepExpect(1'b1, 4'b0001, "single_s0");
    stepExpect(1'b0, 4'b0010, "single_s1");
    stepExpect(1'b0, 4'b0100, "single_s2");
    stepExpect(1'b0, 4'b1000, "single_s3");
    stepExpect(1'b0, 4'b0000, "single_end");
    stepExpect(1'b0, 4'b0000, "single_idle");

    $display("[TB] restart mid-run");
    stepExpect(1'b1, 4'b0001, "restart_s0");
    stepExpect(1'b0, 4'b0010, "restart_s1");
    stepExpect(1'b0, 4'b0100, "restart_s2");
    stepExpect(1'b1, 4'b0001, "restart_reload");
    stepExpect(1'b0, 4'b0010, "restart_r1");
    stepExpect(1'b0, 4'b0100, "restart_r2");
    stepExpect(1'b0, 4'b1000, "restart_r3");
    stepExpect(1'b0, 4'b0000, "restart_end");

    $display("[TB] back-to-back headers");
    stepExpect(1'b1, 4'b0001, "b2b_a0");
    stepExpect(1'b0, 4'b0010, "b2b_a1");
    stepExpect(1'b0, 4'b0100, "b2b_a2");
    stepExpect(1'b0, 4'b1000, "b2b_a3");
    stepExpect(1'b1, 4'b0001, "b2b_b0");
    stepExpect(1'b0, 4'b0010, "b2b_b1");
    stepExpect(1'b0, 4'b0100, "b2b_b2");
    stepExpect(1'b0, 4'b1000, "b2b_b3");
    stepExpect(1'b0, 4'b0000, "b2b_end");

    $display("[TB] held header");
    stepExpect(1'b1, 4'b0001, "held_0");
    stepExpect(1'b1, 4'b0001, "held_1");
    stepExpect(1'b1, 4'b0001, "held_2");
    stepExpect(1'b0, 4'b0010, "held_s1");
    stepExpect(1'b0, 4'b0100, "held_s2");
    stepExpect(1'b0, 4'b1000, "held_s3");
    stepExpect(1'b0, 4'b0000, "held_end");

    $display("[TB] reset abort");
    stepExpect(1'b1, 4'b0001, "abort_s0");
    stepExpect(1'b0, 4'b0010, "abort_s1");
    #2 rst = 1'b0;
    #1 checkOutput("abort_async_clear", stage_ready, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    stepExpect(1'b0, 4'b0000, "abort_idle0");
    stepExpect(1'b0, 4'b0000, "abort_idle1");
    stepExpect(1'b0, 4'b0000, "abort_idle2");
    stepExpect(1'b1, 4'b0001, "abort_restart");
    stepExpect(1'b0, 4'b0010, "abort_restart_s1");

    tuser = 1'b0;
    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
